// File: rtl/ext_pipe.sv
// ----------------------------------------------------------------------------
// ext_pipe
//   Pipelined immediate extender. An OPERAND_WIDTH immediate and a 2-bit mode
//   are accepted over a valid/ready handshake. The extended DATA_WIDTH word is
//   registered and presented one cycle later. A main register plus a skid
//   register (2 entries) let in_ready be a pure register output, so upstream
//   never sees a combinational path from out_ready.
//
// Parameters
//   OPERAND_WIDTH : immediate field width, 2 <= OPERAND_WIDTH < DATA_WIDTH
//   DATA_WIDTH    : datapath word width
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   upstream offers an operand
//   in_ready   out  block accepts an operand this cycle (registered)
//   data_in    in   immediate operand [OPERAND_WIDTH-1:0]
//   mode       in   00 sign-ext, 01 zero-ext, 10 sign-ext then <<1, 11 load-upper
//   out_valid  out  ext_out holds a valid result (registered)
//   out_ready  in   downstream takes the result this cycle
//   ext_out    out  extended result [DATA_WIDTH-1:0] (registered)
//   xfer_cnt   out  [15:0] wrapping count of output transfers
//                   (present only when EXT_XFER_CNT_EN is defined)
//
// Build option
//   EXT_XFER_CNT_EN : adds the xfer_cnt port and its counter. Without it the
//                     block is otherwise identical.
// ----------------------------------------------------------------------------
module ext_pipe #(
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] data_in,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ext_out
`ifdef EXT_XFER_CNT_EN
  ,
  output logic [15:0]              xfer_cnt
`endif
);

  localparam int E = DATA_WIDTH - OPERAND_WIDTH;

  // Elaboration-time guard on the parameter range.
  if (OPERAND_WIDTH < 2 || OPERAND_WIDTH >= DATA_WIDTH) begin : g_bad_params
    $error("ext_pipe: need 2 <= OPERAND_WIDTH < DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   main_q;
  logic [DATA_WIDTH-1:0]   skid_q;
  logic                    in_ready_q;
  logic                    out_valid_q;

  logic                    in_fire;
  logic                    out_fire;
  logic [DATA_WIDTH-1:0]   ext_d;

  // Extension of one immediate according to the selected mode. Mode 10 keeps
  // only the low DATA_WIDTH bits of the doubled sign-extended value.
  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [OPERAND_WIDTH-1:0] imm,
    input logic [1:0]               m
  );
    logic signed [DATA_WIDTH-1:0] sx;
    logic [DATA_WIDTH-1:0]        res;
    sx = {{E{imm[OPERAND_WIDTH-1]}}, imm};
    case (m)
      2'b00:   res = sx;
      2'b01:   res = {{E{1'b0}}, imm};
      2'b10:   res = sx <<< 1;
      default: res = {imm, {E{1'b0}}};
    endcase
    return res;
  endfunction

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign ext_d    = extend(data_in, mode);

  // ---- stage boundary: extended word registered into main/skid ----
  // in_ready/out_valid are updated together with the state so both are
  // registered copies of (state != FULL) and (state != EMPTY).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= ext_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b11: begin
              main_q <= ext_d;
            end
            2'b10: begin
              // Downstream stalled: park the new result behind main.
              skid_q     <= ext_d;
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              state_q     <= EMPTY;
              out_valid_q <= 1'b0;
            end
            default: begin
              state_q <= ONE;
            end
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ext_out   = main_q;

`ifdef EXT_XFER_CNT_EN
  logic [15:0] cnt_q;

  // Counts output transfers; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

  localparam int OW = 11;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] data_in;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] ext_out;
`ifdef EXT_XFER_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ext_pipe #(.OPERAND_WIDTH(OW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ext_out   (ext_out)
`ifdef EXT_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the immediate as an integer and apply the mode rule
  // arithmetically, then reduce modulo 2**DW.
  function automatic logic [DW-1:0] ref_ext(input logic [OW-1:0] d, input logic [1:0] m);
    int sv;
    int r;
    sv = int'(d);
    if (sv >= (1 << (OW - 1))) sv = sv - (1 << OW);
    case (m)
      2'd0:    r = sv;
      2'd1:    r = int'(d);
      2'd2:    r = sv * 2;
      default: r = int'(d) * (1 << (DW - OW));
    endcase
    return DW'(r & ((1 << DW) - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; data_in = '0; mode = 2'd0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (ext_out !== 16'h0000) begin errors++; $display("FAIL reset_ext_out got=%h exp=0000", ext_out); end
`ifdef EXT_XFER_CNT_EN
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [OW-1:0] dv [5];
    logic [1:0]    mv [5];
    logic [DW-1:0] ev [5];
    dv = '{11'h400, 11'h400, 11'h7FF, 11'h001, 11'h3FF};
    mv = '{2'd0,    2'd1,    2'd2,    2'd3,    2'd2};
    ev = '{16'hFC00, 16'h0400, 16'hFFFE, 16'h0020, 16'h07FE};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = dv[i]; mode = mv[i];
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_out_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (ext_out !== ev[i]) begin errors++; $display("FAIL dir_value[%0d] got=%h exp=%h", i, ext_out, ev[i]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    logic [OW-1:0] d [3];
    logic [1:0]    m [3];
    logic [DW-1:0] e [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = OW'($urandom); m[i] = 2'($urandom); e[i] = ref_ext(d[i], m[i]);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = d[0]; mode = m[0];
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_a got=%b exp=1", in_ready); end
    tick();
    data_in = d[1]; mode = m[1];
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_b got=%b exp=1", in_ready); end
    tick();
    data_in = d[2]; mode = m[2];
    for (int k = 0; k < 4; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready[%0d] got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || ext_out !== e[0]) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/%h", k, out_valid, ext_out, e[0]);
      end
      if (k < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || ext_out !== e[1]) begin errors++; $display("FAIL stall_out_b got=%b/%h exp=1/%h", out_valid, ext_out, e[1]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_c got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || ext_out !== e[2]) begin errors++; $display("FAIL stall_out_c got=%b/%h exp=1/%h", out_valid, ext_out, e[2]); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_v;
    logic [DW-1:0] held;
    logic          stall_prev;
    int            sent;
    int            got;
    int            cyc;
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (got < 1000 && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      data_in   = OW'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(1) == 1);
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready, q.size()); end
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b occ=%0d", cyc, out_valid, q.size()); end
      if (stall_prev) begin
        checks++; if (ext_out !== held) begin errors++; $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, ext_out, held); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, ext_out);
        end else begin
          exp_v = q.pop_front();
          if (ext_out !== exp_v) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, ext_out, exp_v); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_ext(data_in, mode));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held = ext_out;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 1000) begin errors++; $display("FAIL rnd_budget got=%0d exp=1000", got); end
  endtask

  task automatic test_reset_full();
    logic [OW-1:0] d;
    logic [1:0]    m;
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = OW'($urandom); mode = 2'($urandom);
    tick();
    data_in = OW'($urandom);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_pre got=%b exp=0", in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_in_ready got=%b exp=1", in_ready); end
    tick();
    rst = 1'b0;
    d = OW'($urandom); m = 2'($urandom);
    out_ready = 1'b1; in_valid = 1'b1; data_in = d; mode = m;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || ext_out !== ref_ext(d, m)) begin
      errors++; $display("FAIL rstfull_first got=%b/%h exp=1/%h", out_valid, ext_out, ref_ext(d, m));
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_drain got=%b exp=0", out_valid); end
  endtask

`ifdef EXT_XFER_CNT_EN
  task automatic test_xfer_cnt();
    int fires;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    fires = 0; cyc = 0;
    in_valid = 1'b1; out_ready = 1'b1; data_in = OW'($urandom); mode = 2'd1;
    while (fires < 65537 && cyc < 70000) begin
      if (out_valid) fires++;
      tick();
      cyc++;
      if (fires == 100) begin
        checks++; if (xfer_cnt !== 16'd100) begin errors++; $display("FAIL cnt_100 got=%0d exp=100", xfer_cnt); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (fires != 65537) begin errors++; $display("FAIL cnt_budget got=%0d exp=65537", fires); end
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL cnt_wrap got=%0d exp=1", xfer_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0; mode = 2'd0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_full();
`ifdef EXT_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
